// File: rtl/ws2812_rx.sv
// rtl/ws2812_rx.sv - WS2812 single-wire receiver: pulse-width decode into indexed GRB words
module ws2812_rx #(
  parameter int T1_MIN     = 29,
  parameter int GLITCH_MAX = 4,
  parameter int RST_CYCLES = 2400,
  parameter int NUM_LEDS   = 144
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  output logic [9:0]  pixel_idx,
  output logic        latch,
  output logic        frame_err,
  output logic        glitch,
  output logic        overflow
);

  localparam int LW = $clog2(RST_CYCLES + 1);
  localparam logic [LW-1:0] LO_MAX   = LW'(RST_CYCLES);
  localparam logic [LW-1:0] LO_PRE   = LW'(RST_CYCLES - 1);
  localparam logic [7:0]    HI_T1    = 8'(T1_MIN);
  localparam logic [7:0]    HI_GL    = 8'(GLITCH_MAX);
  localparam logic [9:0]    WORD_LIM = 10'(NUM_LEDS);

  typedef enum logic [2:0] {SYNC, ARMED, HIGH, LOW, GAP} state_t;

  state_t          state;
  logic            din_m, din_s, din_d;
  logic [7:0]      hi_cnt;
  logic [LW-1:0]   lo_cnt;
  logic [23:0]     shreg;
  logic [4:0]      bit_cnt;
  logic [9:0]      word_cnt;
  logic            got_bit;

  logic            rise, fall;
  logic            gap_hit, sync_hit;
  logic            new_bit;
  logic [23:0]     shifted;

  assign rise     = din_s & ~din_d;
  assign fall     = ~din_s & din_d;
  // Look one cycle ahead so the gap state is entered on the edge the low count reaches its limit.
  assign gap_hit  = ~din_s & (lo_cnt == LO_PRE);
  assign sync_hit = ~din_s & (lo_cnt >= LO_PRE);
  assign new_bit  = (hi_cnt >= HI_T1);
  assign shifted  = {shreg[22:0], new_bit};

  // Two-flop synchronizer plus one delay stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_m <= 1'b0;
      din_s <= 1'b0;
      din_d <= 1'b0;
    end else begin
      din_m <= din;
      din_s <= din_m;
      din_d <= din_s;
    end
  end

  // High-width counter: restarts at 1 on a rise (the rise cycle counts), saturates at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_cnt <= 8'd0;
    end else if (rise) begin
      hi_cnt <= 8'd1;
    end else if (din_s && hi_cnt != 8'hFF) begin
      hi_cnt <= hi_cnt + 8'd1;
    end
  end

  // Low-time counter: cleared on a rise, saturates at the latch gap length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_cnt <= '0;
    end else if (rise) begin
      lo_cnt <= '0;
    end else if (!din_s && lo_cnt != LO_MAX) begin
      lo_cnt <= lo_cnt + 1'b1;
    end
  end

  // Protocol FSM: classifies pulses, assembles words and detects latch gaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SYNC;
      shreg       <= 24'd0;
      bit_cnt     <= 5'd0;
      word_cnt    <= 10'd0;
      got_bit     <= 1'b0;
      pixel_data  <= 24'd0;
      pixel_idx   <= 10'd0;
      pixel_valid <= 1'b0;
      latch       <= 1'b0;
      frame_err   <= 1'b0;
      glitch      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      latch       <= 1'b0;
      frame_err   <= 1'b0;
      glitch      <= 1'b0;
      case (state)
        SYNC: begin
          if (sync_hit) state <= ARMED;
        end
        ARMED: begin
          // Level test so a rise that landed on the gap cycle is still picked up here.
          if (din_s) state <= HIGH;
        end
        HIGH: begin
          if (fall) begin
            state <= LOW;
            if (hi_cnt <= HI_GL) begin
              glitch <= 1'b1;
            end else begin
              got_bit <= 1'b1;
              shreg   <= shifted;
              if (bit_cnt == 5'd23) begin
                bit_cnt <= 5'd0;
                if (word_cnt >= WORD_LIM) begin
                  overflow <= 1'b1;
                end else begin
                  pixel_data  <= shifted;
                  pixel_idx   <= word_cnt;
                  pixel_valid <= 1'b1;
                end
                if (word_cnt != 10'd1023) word_cnt <= word_cnt + 10'd1;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
        end
        LOW: begin
          if (gap_hit) begin
            state     <= GAP;
            latch     <= got_bit;
            frame_err <= (bit_cnt != 5'd0);
            bit_cnt   <= 5'd0;
            word_cnt  <= 10'd0;
            overflow  <= 1'b0;
            got_bit   <= 1'b0;
          end else if (rise) begin
            state <= HIGH;
          end
        end
        GAP: begin
          state <= ARMED;
        end
        default: begin
          state <= SYNC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// tb/tb_ws2812_rx.sv - randomized self-checking bench for ws2812_rx against a pulse-level model
module tb_ws2812_rx;

  localparam int T1   = 29;
  localparam int GL   = 4;
  localparam int RSTC = 2400;
  localparam int NUM  = 144;
  localparam int GAPN = 2420;

  logic        clk = 1'b0;
  logic        rst;
  logic        din;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [9:0]  pixel_idx;
  logic        latch;
  logic        frame_err;
  logic        glitch;
  logic        overflow;

  ws2812_rx dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_idx   (pixel_idx),
    .latch       (latch),
    .frame_err   (frame_err),
    .glitch      (glitch),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [33:0] obs_q[$];
  logic [33:0] exp_q[$];
  int obs_latch = 0, obs_ferr = 0, obs_glitch = 0;
  int exp_latch = 0, exp_ferr = 0, exp_glitch = 0;

  // Reference model: protocol-level view of what the line carried.
  bit          m_synced = 0;
  int          m_bits = 0;
  logic [23:0] m_word = 24'd0;
  int          m_widx = 0;
  bit          m_got = 0;
  bit          m_ovf = 0;

  always @(negedge clk) begin
    if (pixel_valid === 1'b1) obs_q.push_back({pixel_idx, pixel_data});
    if (latch === 1'b1) obs_latch++;
    if (frame_err === 1'b1) obs_ferr++;
    if (glitch === 1'b1) obs_glitch++;
  end

  function automatic int urange(input int lo, input int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  task automatic model_pulse(input int w);
    if (!m_synced) return;
    if (w <= GL) begin
      exp_glitch++;
    end else begin
      m_word = {m_word[22:0], (w >= T1)};
      m_bits++;
      m_got = 1;
      if (m_bits == 24) begin
        m_bits = 0;
        if (m_widx < NUM) exp_q.push_back({10'(m_widx), m_word});
        else m_ovf = 1;
        if (m_widx < 1023) m_widx++;
      end
    end
  endtask

  task automatic model_gap();
    if (!m_synced) begin
      m_synced = 1;
    end else begin
      exp_latch += m_got ? 1 : 0;
      exp_ferr  += (m_bits != 0) ? 1 : 0;
      m_bits = 0;
      m_widx = 0;
      m_got  = 0;
      m_ovf  = 0;
    end
  endtask

  task automatic send_pulse(input int w, input int lo);
    din = 1'b1;
    repeat (w) @(negedge clk);
    din = 1'b0;
    model_pulse(w);
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_gap(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
    model_gap();
  endtask

  task automatic send_bit(input logic b, input int mode);
    int hw, lw;
    case (mode)
      0: begin hw = b ? 38 : 19; lw = 60 - hw; end
      1: begin hw = b ? urange(30, 40) : urange(8, 20); lw = urange(6, 15); end
      default: begin hw = b ? urange(29, 32) : urange(5, 8); lw = 2; end
    endcase
    send_pulse(hw, lw);
  endtask

  task automatic send_word(input logic [23:0] w, input int mode);
    for (int i = 23; i >= 0; i--) send_bit(w[i], mode);
  endtask

  task automatic test_reset();
    din = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (pixel_data !== 24'd0) begin fails++; $display("FAIL reset_data: got %h, expected 000000", pixel_data); end
    tests++; if (pixel_idx !== 10'd0) begin fails++; $display("FAIL reset_idx: got %0d, expected 0", pixel_idx); end
    tests++;
    if ({pixel_valid, latch, frame_err, glitch, overflow} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: got %b, expected 00000", {pixel_valid, latch, frame_err, glitch, overflow});
    end
    rst = 1'b0;
    obs_q.delete(); exp_q.delete();
    send_word(24'($urandom) | 24'h800000, 1);
    send_gap(GAPN);
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL reset_unsynced_words: got %0d, expected 0", obs_q.size()); end
    tests++; if (obs_latch != exp_latch) begin fails++; $display("FAIL reset_unsynced_latch: got %0d, expected %0d", obs_latch, exp_latch); end
  endtask

  task automatic test_basic();
    int vt, lt;
    logic [23:0] w;
    obs_q.delete(); exp_q.delete();
    w = 24'hFF0081;
    for (int i = 23; i >= 1; i--) send_bit(w[i], 0);
    send_pulse(38, 0);
    vt = 0; lt = 0;
    for (int t = 1; t <= GAPN; t++) begin
      @(negedge clk);
      if (pixel_valid === 1'b1 && vt == 0) vt = t;
      if (latch === 1'b1 && lt == 0) lt = t;
    end
    model_gap();
    tests++; if (vt != 3) begin fails++; $display("FAIL basic_valid_latency: got %0d, expected 3", vt); end
    tests++; if (lt != RSTC + 2) begin fails++; $display("FAIL basic_latch_latency: got %0d, expected %0d", lt, RSTC + 2); end
    tests++; if (obs_q.size() != 1) begin fails++; $display("FAIL basic_count: got %0d, expected 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      tests++; if (obs_q[0] !== {10'd0, 24'hFF0081}) begin fails++; $display("FAIL basic_word: got idx=%0d data=%h, expected idx=0 data=ff0081", obs_q[0][33:24], obs_q[0][23:0]); end
    end
    tests++; if (obs_latch != exp_latch) begin fails++; $display("FAIL basic_latch: got %0d, expected %0d", obs_latch, exp_latch); end
    tests++; if (obs_ferr != exp_ferr) begin fails++; $display("FAIL basic_frame_err: got %0d, expected %0d", obs_ferr, exp_ferr); end
  endtask

  task automatic test_overflow();
    obs_q.delete(); exp_q.delete();
    for (int n = 0; n < NUM + 1; n++) send_word(24'($urandom & $urandom & $urandom), 2);
    repeat (3) @(negedge clk);
    tests++; if (overflow !== m_ovf) begin fails++; $display("FAIL ovf_set: got %b, expected %b", overflow, m_ovf); end
    send_gap(GAPN);
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b, expected 0", overflow); end
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL ovf_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL ovf_word%0d: got idx=%0d data=%h, expected idx=%0d data=%h", i, obs_q[i][33:24], obs_q[i][23:0], exp_q[i][33:24], exp_q[i][23:0]); end
    end
    tests++; if (obs_latch != exp_latch) begin fails++; $display("FAIL ovf_latch: got %0d, expected %0d", obs_latch, exp_latch); end
  endtask

  task automatic test_glitch();
    logic [23:0] w;
    obs_q.delete(); exp_q.delete();
    w = 24'h123456;
    for (int i = 23; i >= 0; i--) begin
      send_bit(w[i], 1);
      if (i == 18) send_pulse(2, urange(8, 20));
    end
    send_gap(GAPN);
    tests++; if (obs_glitch != exp_glitch) begin fails++; $display("FAIL glitch_count: got %0d, expected %0d", obs_glitch, exp_glitch); end
    tests++; if (obs_q.size() != 1) begin fails++; $display("FAIL glitch_words: got %0d, expected 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      tests++; if (obs_q[0] !== {10'd0, 24'h123456}) begin fails++; $display("FAIL glitch_word: got idx=%0d data=%h, expected idx=0 data=123456", obs_q[0][33:24], obs_q[0][23:0]); end
    end
  endtask

  task automatic test_frame_err();
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 10; i++) send_bit(1'($urandom), 1);
    send_gap(GAPN);
    tests++; if (obs_ferr != exp_ferr) begin fails++; $display("FAIL ferr_count: got %0d, expected %0d", obs_ferr, exp_ferr); end
    tests++; if (obs_latch != exp_latch) begin fails++; $display("FAIL ferr_latch: got %0d, expected %0d", obs_latch, exp_latch); end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL ferr_no_word: got %0d, expected 0", obs_q.size()); end
    send_word(24'($urandom), 1);
    send_gap(GAPN);
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL ferr_next_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL ferr_next_word: got idx=%0d data=%h, expected idx=%0d data=%h", obs_q[i][33:24], obs_q[i][23:0], exp_q[i][33:24], exp_q[i][23:0]); end
    end
  endtask

  task automatic test_reset_midframe();
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 12; i++) send_bit(1'($urandom), 1);
    din = 1'b0;
    rst = 1'b1;
    m_synced = 0; m_bits = 0; m_widx = 0; m_got = 0; m_ovf = 0;
    repeat (3) @(negedge clk);
    tests++; if (pixel_data !== 24'd0) begin fails++; $display("FAIL midrst_data: got %h, expected 000000", pixel_data); end
    rst = 1'b0;
    repeat (100) @(negedge clk);
    send_word(24'($urandom), 1);
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL midrst_unsynced: got %0d words, expected 0", obs_q.size()); end
    send_gap(GAPN);
    send_word(24'hABCDEF, 1);
    send_gap(GAPN);
    tests++; if (obs_q.size() != 1) begin fails++; $display("FAIL midrst_count: got %0d, expected 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      tests++; if (obs_q[0] !== {10'd0, 24'hABCDEF}) begin fails++; $display("FAIL midrst_word: got idx=%0d data=%h, expected idx=0 data=abcdef", obs_q[0][33:24], obs_q[0][23:0]); end
    end
    tests++; if (obs_latch != exp_latch) begin fails++; $display("FAIL midrst_latch: got %0d, expected %0d", obs_latch, exp_latch); end
  endtask

  task automatic test_thresholds();
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 23; i++) send_pulse(19, 41);
    send_pulse(28, 32);
    for (int i = 0; i < 23; i++) send_pulse(19, 41);
    send_pulse(29, 31);
    send_pulse(4, 20);
    send_pulse(5, 20);
    for (int i = 0; i < 22; i++) send_pulse(19, 41);
    send_pulse(29, 31);
    send_gap(GAPN);
    tests++; if (obs_glitch != exp_glitch) begin fails++; $display("FAIL thr_glitch: got %0d, expected %0d", obs_glitch, exp_glitch); end
    tests++; if (obs_q.size() != 3) begin fails++; $display("FAIL thr_count: got %0d, expected 3", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL thr_word%0d: got idx=%0d data=%h, expected idx=%0d data=%h", i, obs_q[i][33:24], obs_q[i][23:0], exp_q[i][33:24], exp_q[i][23:0]); end
    end
  endtask

  task automatic test_back_to_back();
    obs_q.delete(); exp_q.delete();
    for (int n = 0; n < 8; n++) send_word(24'($urandom), urange(1, 2));
    send_gap(GAPN);
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL b2b_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL b2b_word%0d: got idx=%0d data=%h, expected idx=%0d data=%h", i, obs_q[i][33:24], obs_q[i][23:0], exp_q[i][33:24], exp_q[i][23:0]); end
    end
    tests++; if (obs_latch != exp_latch) begin fails++; $display("FAIL b2b_latch: got %0d, expected %0d", obs_latch, exp_latch); end
    tests++; if (obs_ferr != exp_ferr) begin fails++; $display("FAIL b2b_frame_err: got %0d, expected %0d", obs_ferr, exp_ferr); end
  endtask

  initial begin
    rst = 1'b1;
    din = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_thresholds();
    test_reset_midframe();
    test_back_to_back();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
